// File: rtl/handshake_fifo.sv
// handshake_fifo: valid/ready FIFO with first-word-fall-through head.
// Wrap-bit pointers give count/full/empty straight from registered state.
module handshake_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          s_data_in,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Status and handshakes depend on the pointers only.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
            && (wr_ptr[AW] != rd_ptr[AW]);
    count   = wr_ptr - rd_ptr;
    s_ready = ~full;
    m_valid = ~empty;
    push    = s_valid & s_ready;
    pop     = m_valid & m_ready;
    m_data  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer registers; reset empties the queue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array; contents are left as-is through reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data_in;
  end

endmodule
